// File: rtl/cost_display.sv
// ---------------------------------------------------------------------------
// cost_display
//
// Converts a 14-bit parking cost (cents) to four BCD digits with a sequential
// double-dabble engine, then drives a multiplexed, active-low 4-digit
// 7-segment display that reads DD.CC.
//
// Parameters:
//   REFRESH_DIV  clk cycles each digit stays active (minimum 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cost         cost in cents, unsigned (values above 9999 are clamped)
//   cost_valid   one-cycle strobe qualifying cost
//   busy         high while a conversion is in progress (SHIFT or LOAD)
//   overflow     last displayed cost was clamped to 9999
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low (lit with the dollars-units digit)
//   an           digit anodes, active-low; an[3] thousands .. an[0] units
//
// Build option:
//   COST_DISPLAY_BLANK_EN  blank the thousands digit when it is zero
// ---------------------------------------------------------------------------
module cost_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] cost,
    input  logic        cost_valid,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [13:0] MAX_COST  = 14'd9999;
    localparam logic [3:0]  ITER_LAST = 4'd13;   // 14 iterations: 0..13
    localparam int          CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Conversion state
    state_t      r_state;
    logic        r_busy;
    logic [13:0] r_shift;
    logic [15:0] r_bcd;
    logic [3:0]  r_iter;
    logic        r_clamp;
    logic [13:0] r_pend;
    logic        r_pend_v;
    logic [15:0] r_result;
    logic        r_result_ovf;
    logic        r_commit;

    // Display / scan state
    logic [15:0]      r_display;
    logic             r_overflow;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit_idx;

    logic [13:0] w_src;
    logic [13:0] w_src_clamped;
    logic        w_src_over;
    logic        w_start;
    logic [15:0] w_bcd_adj;
    logic [29:0] w_dd_next;
    logic [3:0]  w_digit;

    // A conversion source is the live input except when leaving LOAD with no
    // fresh strobe, where the buffered value is served. A strobe landing in
    // the LOAD cycle is newer than the buffer, so it wins.
    assign w_src         = (r_state == LOAD && !cost_valid) ? r_pend : cost;
    assign w_src_over    = (w_src > MAX_COST);
    assign w_src_clamped = w_src_over ? MAX_COST : w_src;

    assign w_start = ((r_state == IDLE) && cost_valid) ||
                     ((r_state == LOAD) && (r_pend_v || cost_valid));

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // concatenated {bcd, binary} register left by one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign w_dd_next = {w_bcd_adj, r_shift} << 1;

    // Conversion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
            r_clamp      <= 1'b0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_result     <= '0;
            r_result_ovf <= 1'b0;
            r_commit     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic so
            // every register samples the pre-edge values of its neighbours.
            r_commit <= 1'b0;

            case (r_state)
                SHIFT: begin
                    r_bcd   <= w_dd_next[29:14];
                    r_shift <= w_dd_next[13:0];
                    r_iter  <= r_iter + 4'd1;
                    if (cost_valid) begin
                        r_pend   <= cost;
                        r_pend_v <= 1'b1;
                    end
                    if (r_iter == ITER_LAST)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_result     <= r_bcd;
                    r_result_ovf <= r_clamp;
                    r_commit     <= 1'b1;
                    if (!w_start) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: ;
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Start (or restart back-to-back) a conversion; overrides the
            // LOAD-cycle defaults above and consumes the pending buffer.
            if (w_start) begin
                r_shift  <= w_src_clamped;
                r_clamp  <= w_src_over;
                r_bcd    <= '0;
                r_iter   <= '0;
                r_state  <= SHIFT;
                r_busy   <= 1'b1;
                r_pend_v <= 1'b0;
            end
        end
    end

    // The LOAD result is staged one cycle before reaching the display so a
    // back-to-back conversion may clear the accumulator at the LOAD edge
    // while the finished value still lands on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display  <= '0;
            r_overflow <= 1'b0;
        end else if (r_commit) begin
            r_display  <= r_result;
            r_overflow <= r_result_ovf;
        end
    end

    // Digit scan, free-running and independent of the conversion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_digit = r_display[{r_digit_idx, 2'b00} +: 4];

    always_comb begin
        an  = ~(4'b0001 << r_digit_idx);
        dp  = (r_digit_idx != 2'd2);
        seg = seg_pattern(w_digit);
`ifdef COST_DISPLAY_BLANK_EN
        if (r_digit_idx == 2'd3 && w_digit == 4'd0)
            seg = 7'b1111111;
`endif
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_cost_display.sv
// ---------------------------------------------------------------------------
// tb_cost_display
//
// Directed bench for cost_display with REFRESH_DIV=4. Expected displays are
// computed arithmetically from each strobed cost and queued; a one-entry
// model of the pending buffer tracks strobes issued while busy. Display
// contents are observed through the scanned seg/an/dp outputs.
// ---------------------------------------------------------------------------
module tb_cost_display;

    localparam int REFRESH_DIV = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] cost;
    logic        cost_valid;
    logic        busy;
    logic        overflow;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t cur;
    exp_t m_pend;
    bit   m_pend_v;

    cost_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cost       (cost),
        .cost_valid (cost_valid),
        .busy       (busy),
        .overflow   (overflow),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int c);
        exp_t e;
        int   v;
        v     = (c > 9999) ? 9999 : c;
        e.ovf = (c > 9999);
        e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        return e;
    endfunction

    function automatic logic [6:0] pattern(input logic [3:0] d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? t[d] : 7'b1111111;
    endfunction

    // Compare whatever digit is currently scanned against the expected value.
    task automatic check_disp(input exp_t e, input string tag);
        int         slot;
        logic [3:0] d;
        logic [6:0] s;
        case (an)
            4'b1110: slot = 0;
            4'b1101: slot = 1;
            4'b1011: slot = 2;
            4'b0111: slot = 3;
            default: slot = -1;
        endcase
        check({tag, "_an_onehot"}, {31'b0, slot >= 0}, 32'd1);
        if (slot >= 0) begin
            d = e.bcd[slot*4 +: 4];
            s = pattern(d);
`ifdef COST_DISPLAY_BLANK_EN
            if (slot == 3 && d == 4'd0) s = 7'b1111111;
`endif
            check({tag, "_seg"}, {25'b0, seg}, {25'b0, s});
            check({tag, "_dp"}, {31'b0, dp}, {31'b0, slot != 2});
        end
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
        check({tag, "_an"}, {28'b0, an}, 32'b1110);
        check({tag, "_seg"}, {25'b0, seg}, 32'b1000000);
        check({tag, "_dp"}, {31'b0, dp}, 32'd1);
    endtask

    // Strobe one cost; the model either queues it or places it in pending.
    task automatic send(input int c, input bit in_flight);
        if (in_flight) begin
            m_pend   = model(c);
            m_pend_v = 1'b1;
        end else begin
            exp_q.push_back(model(c));
        end
        @(negedge clk);
        cost       = 14'(c);
        cost_valid = 1'b1;
        @(negedge clk);
        cost_valid = 1'b0;
    endtask

    task automatic next_expected();
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd0, 32'd1);
        end else begin
            cur = exp_q.pop_front();
            if (m_pend_v) begin
                exp_q.push_back(m_pend);
                m_pend_v = 1'b0;
            end
        end
    endtask

    // Single conversion from IDLE: returns at the negedge after the strobe.
    // busy is high for 15 samples, the old value holds through sample 15 and
    // the new value appears after the 16th edge.
    task automatic convert(input int c, input string tag);
        send(c, 1'b0);
        for (int k = 0; k < 15; k++) begin
            check({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
            check_disp(cur, {tag, "_hold"});
            @(negedge clk);
        end
        check({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
        check_disp(cur, {tag, "_preload"});
        @(negedge clk);
        next_expected();
        for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
            check({tag, "_idle"}, {31'b0, busy}, 32'd0);
            check_disp(cur, tag);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        rst_n      = 1'b1;
        cost       = '0;
        cost_valid = 1'b0;
        m_pend_v   = 1'b0;
        cur        = model(0);

        // Reset values
        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Scan order: units, tens, dollars, thousands, each for REFRESH_DIV cycles
        for (int j = 0; j < 5 * REFRESH_DIV; j++) begin
            exp_an = 4'b0001 << ((j / REFRESH_DIV) % 4);
            exp_an = ~exp_an;
            check("scan_an", {28'b0, an}, {28'b0, exp_an});
            check_disp(cur, "scan");
            @(negedge clk);
        end

        convert(1234, "conv1234");
        convert(10000, "clamp");
        convert(5, "after_clamp");
        convert(0, "zero");

        // Back-to-back: 500 then 777 and 888 while busy; 888 overwrites 777.
        send(500, 1'b0);
        send(777, 1'b1);
        send(888, 1'b1);
        for (int j = 4; j < 47; j++) begin
            if (j == 16 || j == 31) next_expected();
            check("pend_busy", {31'b0, busy}, {31'b0, j < 30});
            check_disp(cur, "pend");
            @(negedge clk);
        end

        // Reset in the middle of converting 4321 (after the 7th iteration)
        send(4321, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        m_pend_v = 1'b0;
        cur      = model(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 24; j++) begin
            check("post_reset_busy", {31'b0, busy}, 32'd0);
            check_disp(cur, "post_reset");
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
